sobel_window_ctrl: RTL

//  Streaming controller for the combinational sobel_module. Accepts a raster-order pixel stream.

---
 rtl/sobel_window_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sobel_window_ctrl.sv
// Streaming 3x3 window controller feeding a combinational Sobel datapath.
// Define SOBEL_PIPE_REG_EN to register sobel_result once more (2-cycle result latency).
module sobel_window_ctrl #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned PIX_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PIX_W-1:0] threshold_in,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] p0,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic [PIX_W-1:0] p8,
  output logic [PIX_W-1:0] threshold,
  input  logic             sobel_result,
  output logic             edge_out,
  output logic             edge_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] ColLast = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

  state_e           state_q;
  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;
  logic [PIX_W-1:0] lb0 [IMG_WIDTH];
  logic [PIX_W-1:0] lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] win_q [3][3];  // [row][col], row 0 is the oldest line
  logic             win_vld_q;     // window now held is complete
  logic             last_vld;
  logic             last_res;
  logic             drained;
  logic             accept;

  assign pix_ready = (state_q == StStream);
  assign busy      = (state_q != StIdle);
  assign accept    = pix_valid && (state_q == StStream);

  assign p0 = win_q[0][0];
  assign p1 = win_q[0][1];
  assign p2 = win_q[0][2];
  assign p3 = win_q[1][0];
  assign p5 = win_q[1][2];
  assign p6 = win_q[2][0];
  assign p7 = win_q[2][1];
  assign p8 = win_q[2][2];

`ifdef SOBEL_PIPE_REG_EN
  logic pipe_vld_q;
  logic pipe_res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= 1'b0;
      pipe_res_q <= 1'b0;
    end else begin
      pipe_vld_q <= win_vld_q;
      pipe_res_q <= sobel_result;
    end
  end

  assign last_vld = pipe_vld_q;
  assign last_res = pipe_res_q;
  // The final output is only the last one once no window is still waiting behind it.
  assign drained  = !win_vld_q;
`else
  assign last_vld = win_vld_q;
  assign last_res = sobel_result;
  assign drained  = 1'b1;
`endif

  // Line buffers carry no reset; their contents are rewritten before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col_q] <= lb0[col_q];
      lb0[col_q] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      threshold  <= '0;
      win_vld_q  <= 1'b0;
      edge_out   <= 1'b0;
      edge_valid <= 1'b0;
      frame_done <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      frame_done <= 1'b0;
      edge_valid <= last_vld;
      edge_out   <= last_vld & last_res;
      win_vld_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            threshold <= threshold_in;
            col_q     <= '0;
            row_q     <= '0;
            state_q   <= StStream;
          end
        end
        StStream: begin
          if (pix_valid) begin
            for (int r = 0; r < 3; r++) begin
              win_q[r][0] <= win_q[r][1];
              win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb1[col_q];
            win_q[1][2] <= lb0[col_q];
            win_q[2][2] <= pix_in;
            win_vld_q   <= (row_q >= RW'(2)) && (col_q >= CW'(2));
            if (col_q == ColLast) begin
              col_q <= '0;
              if (row_q == RowLast) begin
                row_q   <= '0;
                state_q <= StFlush;
              end else begin
                row_q <= row_q + RW'(1);
              end
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        StFlush: begin
          if (last_vld && drained) begin
            frame_done <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
